// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: per-digit slots with anti-ghost blanking,
// PWM brightness, leading-zero suppression and a per-frame input snapshot.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 8,
  parameter int SLOT_TICKS  = 16,
  parameter int BLANK_TICKS = 2,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   anodes_mask,
  input  logic                    lzs,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [31:0] BLANK_U = BLANK_TICKS;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(SLOT_TICKS - 1);

  logic [IW-1:0]           idx_q, idx_d;
  logic [TW-1:0]           t_q, t_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    lzs_q, lzs_d;
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]              segments_q, segments_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_start_q, frame_start_d;

  logic                    snap;
  logic [4*NUM_DIGITS-1:0] eff_digits;
  logic [NUM_DIGITS-1:0]   eff_dp, eff_mask, supp;
  logic                    eff_lzs, zero_run, show, lit;
  logic [3:0]              cur_nib;
  logic [31:0]             t_ext;

  function automatic logic [6:0] seg_enc(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    // The frame-start edge renders from the live inputs it is capturing.
    snap       = ce && (idx_q == '0) && (t_q == '0);
    eff_digits = snap ? digits      : digits_q;
    eff_dp     = snap ? dp          : dp_q;
    eff_mask   = snap ? anodes_mask : mask_q;
    eff_lzs    = snap ? lzs         : lzs_q;

    zero_run = 1'b1;
    supp     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (eff_digits[4*i +: 4] == 4'h0) & ~eff_dp[i];
      supp[i]  = eff_lzs & zero_run & (i != 0);
    end

    cur_nib = eff_digits[{idx_q, 2'b00} +: 4];
    show    = eff_mask[idx_q] & ~supp[idx_q];
    t_ext   = 32'(t_q);
    lit     = show && (t_ext >= BLANK_U) && ((t_ext - BLANK_U) < 32'(brightness));

    t_d           = t_q;
    idx_d         = idx_q;
    digits_d      = digits_q;
    dp_d          = dp_q;
    mask_d        = mask_q;
    lzs_d         = lzs_q;
    anodes_d      = anodes_q;
    segments_d    = segments_q;
    dp_n_d        = dp_n_q;
    frame_start_d = snap;

    if (ce) begin
      if (t_q == T_LAST) begin
        t_d   = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        t_d = t_q + 1'b1;
      end
      anodes_d = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      if (t_q == '0) begin
        segments_d = show ? seg_enc(cur_nib) : 7'h7F;
        dp_n_d     = show ? ~eff_dp[idx_q] : 1'b1;
      end
    end

    if (snap) begin
      digits_d = digits;
      dp_d     = dp;
      mask_d   = anodes_mask;
      lzs_d    = lzs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      t_q           <= '0;
      digits_q      <= '0;
      dp_q          <= '0;
      mask_q        <= '0;
      lzs_q         <= 1'b0;
      anodes_q      <= '1;
      segments_q    <= 7'h7F;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      t_q           <= t_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      mask_q        <= mask_d;
      lzs_q         <= lzs_d;
      anodes_q      <= anodes_d;
      segments_q    <= segments_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anodes      = anodes_q;
  assign segments    = segments_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan at default parameters: expected pin values
// are queued per ce edge since reset and checked by an independent monitor.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  anodes_mask = '0;
  logic        lzs = 1'b0;
  logic [3:0]  brightness = '0;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        dp_n;
  logic        frame_start;

  seven_seg_scan dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .digits(digits), .dp(dp),
    .anodes_mask(anodes_mask), .lzs(lzs), .brightness(brightness),
    .anodes(anodes), .segments(segments), .dp_n(dp_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dpn;
    logic       fs;
  } exp_t;

  localparam logic [6:0] SEG_HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t sb[$];
  int   vec = 0;
  int   misc = 0;
  int   n_edges = 0;
  logic ce_seen = 1'b0;
  exp_t last;
  bit   have_last = 0;

  // ce edges since reset release; edge k renders scan position k-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edges = 0;
      ce_seen = 1'b0;
    end else begin
      ce_seen = ce;
      if (ce) n_edges++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].edge_n < n_edges) begin
      e = sb.pop_front();
      vec++; misc++;
      $display("FAIL missed e=%0d (now at %0d)", e.edge_n, n_edges);
    end
    if (sb.size() > 0 && sb[0].edge_n == n_edges) begin
      e = sb.pop_front();
      vec++;
      if (anodes !== e.an || segments !== e.seg || dp_n !== e.dpn || frame_start !== e.fs) begin
        misc++;
        $display("FAIL scan e=%0d: got an=%h seg=%h dp_n=%b fs=%b, want an=%h seg=%h dp_n=%b fs=%b",
                 e.edge_n, anodes, segments, dp_n, frame_start, e.an, e.seg, e.dpn, e.fs);
      end
      last = e;
      have_last = (e.edge_n != 0);
    end else if (have_last && rst_n && !ce_seen) begin
      vec++;
      if (anodes !== last.an || segments !== last.seg || dp_n !== last.dpn || frame_start !== 1'b0) begin
        misc++;
        $display("FAIL hold after e=%0d: got an=%h seg=%h dp_n=%b fs=%b, want an=%h seg=%h dp_n=%b fs=0",
                 last.edge_n, anodes, segments, dp_n, frame_start, last.an, last.seg, last.dpn);
      end
    end
  end

  function automatic logic [55:0] mkseg(input logic [31:0] dig);
    logic [55:0] s;
    for (int i = 0; i < 8; i++) s[i*7 +: 7] = SEG_HEX[dig[i*4 +: 4]];
    return s;
  endfunction

  // Hand tables: vis = digits expected visible, segv/dpv their glyphs, lit_len = lit ticks after blanking.
  task automatic push_range(input int e0, input int e1, input int lit_len, input logic [7:0] vis,
                            input logic [55:0] segv, input logic [7:0] dpv);
    for (int e = e0; e <= e1; e++) begin
      int p, idx, t;
      exp_t x;
      p   = e - 1;
      idx = (p / 16) % 8;
      t   = p % 16;
      x.edge_n = e;
      x.an  = (vis[idx] && t >= 2 && (t - 2) < lit_len) ? ~(8'd1 << idx) : 8'hFF;
      x.seg = vis[idx] ? segv[idx*7 +: 7] : 7'h7F;
      x.dpn = vis[idx] ? ~dpv[idx] : 1'b1;
      x.fs  = (p % 128) == 0;
      sb.push_back(x);
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    ce    = 1'b0;
    sb.push_back('{0, 8'hFF, 7'h7F, 1'b1, 1'b0});
  endtask

  task automatic begin_test();
    @(posedge clk);
    #1;
    assert_reset();
  endtask

  task automatic release_rst(input logic ce_val);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ce    = ce_val;
  endtask

  task automatic drain(input string name);
    int g = 0;
    while (sb.size() > 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() > 0) begin
      vec++; misc++;
      $display("FAIL timeout %s: %0d expectations left, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    // Basic scan, full brightness, dp on digit 2
    begin_test();
    digits = 32'h7654_3210; dp = 8'h04; anodes_mask = 8'hFF; lzs = 1'b0; brightness = 4'd15;
    push_range(1, 256, 15, 8'hFF, mkseg(32'h7654_3210), 8'h04);
    release_rst(1'b1);
    drain("basic");

    // Brightness 3, digit 7 masked
    begin_test();
    digits = 32'h7654_3210; dp = 8'h00; anodes_mask = 8'h7F; brightness = 4'd3;
    push_range(1, 128, 3, 8'h7F, mkseg(32'h7654_3210), 8'h00);
    release_rst(1'b1);
    drain("bright3");

    // Leading-zero suppression: 0x00000105 shows 5,0,1 and blanks 3..7
    begin_test();
    digits = 32'h0000_0105; dp = 8'h00; anodes_mask = 8'hFF; lzs = 1'b1; brightness = 4'd15;
    push_range(1, 128, 15, 8'h07, {35'h7_FFFF_FFFF, 7'h79, 7'h40, 7'h12}, 8'h00);
    release_rst(1'b1);
    drain("lzs");

    // Mid-frame input change is deferred to the next frame
    begin_test();
    digits = 32'h1111_1111; lzs = 1'b0; brightness = 4'd15;
    push_range(1, 128, 15, 8'hFF, {8{7'h79}}, 8'h00);
    push_range(129, 256, 15, 8'hFF, {8{7'h24}}, 8'h00);
    release_rst(1'b1);
    repeat (53) @(negedge clk);
    digits = 32'h2222_2222;
    drain("tearing");

    // ce one clock in four
    begin_test();
    digits = 32'h7654_3210; brightness = 4'd3;
    push_range(1, 40, 3, 8'hFF, mkseg(32'h7654_3210), 8'h00);
    release_rst(1'b0);
    for (int c = 0; c < 160; c++) begin
      ce = (c % 4 == 3);
      @(negedge clk);
    end
    ce = 1'b0;
    drain("ce_div4");

    // Async reset at idx 5, t 7, then restart from digit 0
    begin_test();
    brightness = 4'd15;
    push_range(1, 86, 15, 8'hFF, mkseg(32'h7654_3210), 8'h00);
    release_rst(1'b1);
    repeat (87) @(posedge clk);
    #1;
    assert_reset();
    push_range(1, 32, 15, 8'hFF, mkseg(32'h7654_3210), 8'h00);
    release_rst(1'b1);
    drain("reset_mid");

    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end

endmodule
